// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC capture-buffer reader.
// Holds the FSM state encoding, the BRAM word stride and default geometry.
package tdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } tdc_state_t;

   localparam int          ADDR_STRIDE   = 4;
   localparam int          DEF_ADDR_W    = 15;
   localparam logic [14:0] DEF_LAST_ADDR = 15'h7FFC;

   // Output buffer entry: 8-bit sample plus the last-word flag.
   localparam int          FIFO_W        = 9;

endpackage

// File: rtl/tdc_rd_fifo.sv
// Small synchronous FIFO buffering BRAM returns ahead of the output stream.
// Flush empties it in one cycle and overrides any push or pop in that cycle.
module tdc_rd_fifo
   import tdc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = FIFO_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/tdc_buf_reader.sv
// Reads the TDC capture BRAM out through port B and streams the low byte of
// each word as an AXI-Stream beat, with credit-based flow control into a FIFO.
module tdc_buf_reader
   import tdc_pkg::*;
#(
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEF_LAST_ADDR),
   parameter int                RD_LAT     = 1,
   parameter int                FIFO_DEPTH = 4
)(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              clkb,
   output logic              rstb,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   output logic [3:0]        web,
   output logic [31:0]       datab,
   input  logic [31:0]       rd_data,
   output logic [7:0]        m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast
);

   localparam int                CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);

   tdc_state_t          r_state;
   tdc_state_t          w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [RD_LAT-1:0]   r_vld;
   logic [RD_LAT-1:0]   r_last;
   logic                r_last_sent;

   logic [CNT_W-1:0]    w_fifo_count;
   logic [CNT_W-1:0]    w_in_flight;
   logic [CNT_W:0]      w_used;
   logic                w_credit;
   logic                w_issue;
   logic                w_issue_last;
   logic                w_abort;
   logic                w_flush;
   logic                w_push;
   logic                w_pop;
   logic                w_fifo_empty;
   logic                w_fifo_full;
   logic [FIFO_W-1:0]   w_push_data;
   logic [FIFO_W-1:0]   w_pop_data;
   logic                w_unused;

   // Port B is a read-only port clocked from the system clock.
   assign clkb  = sys_clk;
   assign rstb  = 1'b0;
   assign web   = 4'b0000;
   assign datab = 32'h0000_0000;
   assign addrb = r_addr;

   // Credit counts FIFO slots not already claimed by stored or in-flight words.
   assign w_in_flight  = CNT_W'($countones(r_vld));
   assign w_used       = {1'b0, w_fifo_count} + {1'b0, w_in_flight};
   assign w_credit     = (w_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign w_issue      = enb;
   assign w_issue_last = (r_addr == LAST_ADDR);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_READ;
         end
         ST_READ: begin
            if (!start)                        w_state_nxt = ST_IDLE;
            else if (w_issue && w_issue_last)  w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!start) w_state_nxt = ST_IDLE;
            else if (w_in_flight == '0 && w_fifo_empty && r_last_sent)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (!start) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      enb     = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         ST_READ: begin
            busy    = 1'b1;
            w_abort = !start;
            enb     = start && w_credit;
         end
         ST_DRAIN: begin
            busy    = 1'b1;
            w_abort = !start;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // IDLE keeps the buffer and read pipeline empty so every run starts clean.
   assign w_flush = (r_state == ST_IDLE) || w_abort;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                       r_addr <= '0;
      else if (r_state == ST_IDLE)          r_addr <= '0;
      else if (w_issue && !w_issue_last)    r_addr <= r_addr + STRIDE;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_vld <= '0;
      end else if (w_flush) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_issue;
         for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   // Last flag rides alongside the valid bit; it is only looked at when valid.
   always_ff @(posedge sys_clk) begin
      r_last[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) r_last[i] <= r_last[i-1];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                         r_last_sent <= 1'b0;
      else if (w_flush)                       r_last_sent <= 1'b0;
      else if (w_pop && w_pop_data[8])        r_last_sent <= 1'b1;
   end

   assign w_push      = r_vld[RD_LAT-1];
   assign w_push_data = {r_last[RD_LAT-1], rd_data[7:0]};
   assign w_pop       = m_tvalid && m_tready;
   assign w_unused    = ^rd_data[31:8];

   tdc_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_pop_data),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign m_tvalid = !w_fifo_empty;
   assign m_tdata  = w_pop_data[7:0];
   assign m_tlast  = w_pop_data[8] && !w_fifo_empty;

   // The credit rule must make a push into a full buffer impossible.
   a_fifo_no_overflow: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
      !(w_push && !w_flush && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_tdc_buf_reader.sv
// Scoreboard bench for tdc_buf_reader: default build plus an RD_LAT=2, 8-word build.
module tb_tdc_buf_reader;

   localparam int             AW    = 15;
   localparam logic [AW-1:0]  LAST1 = 15'h7FFC;
   localparam int             NB1   = 8192;
   localparam logic [AW-1:0]  LAST2 = 15'h001C;
   localparam int             NB2   = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          start, m_tready, start2, m_tready2;
   logic          busy, done, clkb, rstb, enb, m_tvalid, m_tlast;
   logic          busy2, done2, clkb2, rstb2, enb2, m_tvalid2, m_tlast2;
   logic [AW-1:0] addrb, addrb2;
   logic [3:0]    web, web2;
   logic [31:0]   datab, datab2, rd_data, rd_data2, r_s1b;
   logic [7:0]    m_tdata, m_tdata2;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [8:0]    exp_q[$];

   always #5 sys_clk = ~sys_clk;

   tdc_buf_reader u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .busy(busy), .done(done),
      .clkb(clkb), .rstb(rstb), .enb(enb), .addrb(addrb), .web(web), .datab(datab),
      .rd_data(rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast));

   tdc_buf_reader #(.ADDR_W(AW), .LAST_ADDR(LAST2), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .busy(busy2), .done(done2),
      .clkb(clkb2), .rstb(rstb2), .enb(enb2), .addrb(addrb2), .web(web2), .datab(datab2),
      .rd_data(rd_data2), .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready2),
      .m_tlast(m_tlast2));

   // Word i holds i in its low byte; upper bytes are distinct filler.
   function automatic logic [31:0] word_of(input logic [AW-1:0] a);
      logic [12:0] idx;
      idx = a[14:2];
      return {8'hA5, 3'b000, idx, idx[7:0]};
   endfunction

   always @(posedge sys_clk) begin
      if (enb)  rd_data <= word_of(addrb);
      if (enb2) r_s1b   <= word_of(addrb2);
      rd_data2 <= r_s1b;
   end

   task automatic test_reset();
      sys_rst_n = 1'b0; start = 1'b0; start2 = 1'b0; m_tready = 1'b1; m_tready2 = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
      n_cmp++; if (enb !== 1'b0)    begin n_err++; $display("FAIL rst_enb: got %b expected 0", enb); end
      n_cmp++; if (addrb !== '0)    begin n_err++; $display("FAIL rst_addrb: got %h expected 0", addrb); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
      n_cmp++; if (m_tlast !== 1'b0)  begin n_err++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
      n_cmp++; if ({rstb, web, datab} !== 37'd0) begin n_err++; $display("FAIL rst_ties: got %h expected 0", {rstb, web, datab}); end
      n_cmp++; if (clkb !== sys_clk) begin n_err++; $display("FAIL rst_clkb: got %b expected %b", clkb, sys_clk); end
      n_cmp++; if ({busy2, done2, enb2, m_tvalid2, rstb2, web2, datab2, clkb2} !== 41'd0)
         begin n_err++; $display("FAIL rst_dut2: got %h expected 0", {busy2, done2, enb2, m_tvalid2}); end
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_cmp++; if (busy !== 1'b0 || enb !== 1'b0) begin n_err++; $display("FAIL idle_no_start: got busy=%b enb=%b expected 0", busy, enb); end
   endtask

   task automatic test_full_stream();
      int cyc = 0, beats = 0, issued = 0, first_cyc = -1, last_cyc = -1;
      logic [AW-1:0] exp_addr = '0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < NB1; i++) exp_q.push_back({(i == NB1 - 1), 8'(i)});
      m_tready = 1'b1;
      @(negedge sys_clk); start = 1'b1;
      while (cyc < NB1 + 100 && done !== 1'b1) begin
         @(negedge sys_clk);
         if (enb) begin
            n_cmp++; if (addrb !== exp_addr) begin n_err++; $display("FAIL full_addr: got %h expected %h", addrb, exp_addr); end
            exp_addr = exp_addr + AW'(4); issued++;
         end
         if (m_tvalid && m_tready) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc; beats++;
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL full_extra: got %h expected no beat", {m_tlast, m_tdata}); end
            else begin
               e = exp_q.pop_front();
               if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL full_beat%0d: got %h expected %h", beats - 1, {m_tlast, m_tdata}, e); end
            end
         end
         cyc++;
      end
      n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL full_done: got %b expected 1", done); end
      n_cmp++; if (beats != NB1)     begin n_err++; $display("FAIL full_beats: got %0d expected %0d", beats, NB1); end
      n_cmp++; if (issued != NB1)    begin n_err++; $display("FAIL full_issued: got %0d expected %0d", issued, NB1); end
      n_cmp++; if (first_cyc != 2)   begin n_err++; $display("FAIL full_latency: got %0d expected 2", first_cyc); end
      n_cmp++; if (last_cyc - first_cyc != NB1 - 1) begin n_err++; $display("FAIL full_rate: got %0d expected %0d", last_cyc - first_cyc, NB1 - 1); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL full_busy: got %b expected 0", busy); end
      repeat (5) @(negedge sys_clk);
      n_cmp++; if (done !== 1'b1 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL full_hold: got done=%b tvalid=%b expected 1/0", done, m_tvalid); end
      start = 1'b0;
      @(negedge sys_clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_to_idle: got done=%b busy=%b expected 0/0", done, busy); end
   endtask

   task automatic test_backpressure();
      int cyc = 0, beats = 0, issued = 0, max_out = 0;
      logic pv = 1'b0;
      logic [8:0] pd = '0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < NB1; i++) exp_q.push_back({(i == NB1 - 1), 8'(i)});
      m_tready = 1'b0;
      @(negedge sys_clk); start = 1'b1;
      while (cyc < 3 * NB1 + 200 && done !== 1'b1) begin
         @(negedge sys_clk);
         m_tready = (cyc % 3 == 0);
         if (pv) begin
            n_cmp++;
            if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== pd)
               begin n_err++; $display("FAIL bp_stable: got v=%b %h expected v=1 %h", m_tvalid, {m_tlast, m_tdata}, pd); end
         end
         if (enb) issued++;
         if (m_tvalid && m_tready) begin
            beats++; n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_extra: got %h expected no beat", {m_tlast, m_tdata}); end
            else begin
               e = exp_q.pop_front();
               if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL bp_beat%0d: got %h expected %h", beats - 1, {m_tlast, m_tdata}, e); end
            end
         end
         pv = m_tvalid && !m_tready;
         pd = {m_tlast, m_tdata};
         if (issued - beats > max_out) max_out = issued - beats;
         cyc++;
      end
      n_cmp++; if (done !== 1'b1)  begin n_err++; $display("FAIL bp_done: got %b expected 1", done); end
      n_cmp++; if (beats != NB1)   begin n_err++; $display("FAIL bp_beats: got %0d expected %0d", beats, NB1); end
      n_cmp++; if (max_out != 4)   begin n_err++; $display("FAIL bp_outstanding: got %0d expected 4", max_out); end
      start = 1'b0; m_tready = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_stall_start();
      int issued = 0, beats = 0;
      logic [AW-1:0] exp_addr = '0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, 8'(i)});
      m_tready = 1'b0;
      @(negedge sys_clk); start = 1'b1;
      for (int c = 0; c < 62; c++) begin
         @(negedge sys_clk);
         m_tready = (c >= 50);
         if (c == 50) begin
            n_cmp++; if (issued != 4)     begin n_err++; $display("FAIL stall_issued: got %0d expected 4", issued); end
            n_cmp++; if (enb !== 1'b0)    begin n_err++; $display("FAIL stall_enb: got %b expected 0", enb); end
            n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL stall_tvalid: got %b expected 1", m_tvalid); end
         end
         if (enb) begin
            n_cmp++; if (addrb !== exp_addr) begin n_err++; $display("FAIL stall_addr: got %h expected %h", addrb, exp_addr); end
            exp_addr = exp_addr + AW'(4); issued++;
         end
         if (m_tvalid && m_tready) begin
            beats++; n_cmp++;
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL stall_beat%0d: got %h expected %h", beats - 1, {m_tlast, m_tdata}, e); end
         end
      end
      m_tready = 1'b0; start = 1'b0;
      @(negedge sys_clk);
      n_cmp++; if ({busy, m_tvalid, m_tlast, enb} !== 4'b0000)
         begin n_err++; $display("FAIL stall_abort: got busy/tvalid/tlast/enb=%b expected 0000", {busy, m_tvalid, m_tlast, enb}); end
   endtask

   task automatic test_abort_restart();
      int cyc = 0, beats = 0;
      logic seen_v = 1'b0;
      logic [AW-1:0] exp_addr = '0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < NB1; i++) exp_q.push_back({(i == NB1 - 1), 8'(i)});
      m_tready = 1'b1;
      @(negedge sys_clk); start = 1'b1;
      while (cyc < 300 && beats < 101) begin
         @(negedge sys_clk);
         if (m_tvalid && m_tready) begin
            beats++; n_cmp++;
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL abort_beat%0d: got %h expected %h", beats - 1, {m_tlast, m_tdata}, e); end
            if (beats == 101) start = 1'b0;
         end
         cyc++;
      end
      @(negedge sys_clk);
      n_cmp++; if ({busy, done, m_tvalid, m_tlast, enb} !== 5'b00000)
         begin n_err++; $display("FAIL abort_idle: got busy/done/tvalid/tlast/enb=%b expected 00000", {busy, done, m_tvalid, m_tlast, enb}); end
      repeat (5) begin @(negedge sys_clk); if (m_tvalid) seen_v = 1'b1; end
      n_cmp++; if (seen_v !== 1'b0) begin n_err++; $display("FAIL abort_quiet: got tvalid %b expected 0", seen_v); end
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 8'(i)});
      beats = 0; cyc = 0;
      start = 1'b1;
      while (cyc < 40 && beats < 10) begin
         @(negedge sys_clk);
         if (enb) begin
            n_cmp++; if (addrb !== exp_addr) begin n_err++; $display("FAIL restart_addr: got %h expected %h", addrb, exp_addr); end
            exp_addr = exp_addr + AW'(4);
         end
         if (m_tvalid && m_tready) begin
            beats++; n_cmp++;
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL restart_beat%0d: got %h expected %h", beats - 1, {m_tlast, m_tdata}, e); end
            if (beats == 10) start = 1'b0;
         end
         cyc++;
      end
      n_cmp++; if (beats != 10) begin n_err++; $display("FAIL restart_beats: got %0d expected 10", beats); end
      @(negedge sys_clk);
   endtask

   task automatic test_reset_in_drain();
      int cyc = 0;
      logic seen_v = 1'b0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < NB1; i++) exp_q.push_back({(i == NB1 - 1), 8'(i)});
      m_tready = 1'b1;
      @(negedge sys_clk); start = 1'b1;
      while (cyc < NB1 + 100) begin
         @(negedge sys_clk);
         if (m_tvalid && m_tready) begin
            n_cmp++;
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin n_err++; $display("FAIL drain_beat: got %h expected %h", {m_tlast, m_tdata}, e); end
         end
         cyc++;
         if (enb && addrb == LAST1) break;
      end
      @(negedge sys_clk);
      n_cmp++; if ({busy, enb, m_tvalid} !== 3'b101) begin n_err++; $display("FAIL drain_state: got busy/enb/tvalid=%b expected 101", {busy, enb, m_tvalid}); end
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++; if ({busy, done, enb, m_tvalid, m_tlast} !== 5'b00000)
         begin n_err++; $display("FAIL async_rst: got busy/done/enb/tvalid/tlast=%b expected 00000", {busy, done, enb, m_tvalid, m_tlast}); end
      n_cmp++; if (addrb !== '0) begin n_err++; $display("FAIL async_rst_addr: got %h expected 0", addrb); end
      exp_q.delete();
      start = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (20) begin @(negedge sys_clk); if (m_tvalid || busy) seen_v = 1'b1; end
      n_cmp++; if (seen_v !== 1'b0) begin n_err++; $display("FAIL post_rst_quiet: got %b expected 0", seen_v); end
   endtask

   task automatic test_rdlat2();
      int cyc = 0, beats = 0, issued = 0, first_cyc = -1, last_cyc = -1;
      logic [AW-1:0] exp_addr = '0;
      logic [8:0] e;
      exp_q.delete();
      for (int i = 0; i < NB2; i++) exp_q.push_back({(i == NB2 - 1), 8'(i)});
      m_tready2 = 1'b1;
      @(negedge sys_clk); start2 = 1'b1;
      while (cyc < 100 && done2 !== 1'b1) begin
         @(negedge sys_clk);
         if (enb2) begin
            n_cmp++; if (addrb2 !== exp_addr) begin n_err++; $display("FAIL lat2_addr: got %h expected %h", addrb2, exp_addr); end
            exp_addr = exp_addr + AW'(4); issued++;
         end
         if (m_tvalid2 && m_tready2) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc; beats++; n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL lat2_extra: got %h expected no beat", {m_tlast2, m_tdata2}); end
            else begin
               e = exp_q.pop_front();
               if ({m_tlast2, m_tdata2} !== e) begin n_err++; $display("FAIL lat2_beat%0d: got %h expected %h", beats - 1, {m_tlast2, m_tdata2}, e); end
            end
         end
         cyc++;
      end
      n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL lat2_done: got %b expected 1", done2); end
      n_cmp++; if (beats != NB2)   begin n_err++; $display("FAIL lat2_beats: got %0d expected %0d", beats, NB2); end
      n_cmp++; if (issued != NB2)  begin n_err++; $display("FAIL lat2_issued: got %0d expected %0d", issued, NB2); end
      n_cmp++; if (first_cyc != 3) begin n_err++; $display("FAIL lat2_latency: got %0d expected 3", first_cyc); end
      n_cmp++; if (last_cyc - first_cyc != NB2 - 1) begin n_err++; $display("FAIL lat2_rate: got %0d expected %0d", last_cyc - first_cyc, NB2 - 1); end
      repeat (5) @(negedge sys_clk);
      n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL lat2_hold: got %b expected 1", done2); end
      start2 = 1'b0;
      @(negedge sys_clk);
      n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL lat2_release: got %b expected 0", done2); end
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_backpressure();
      test_stall_start();
      test_abort_restart();
      test_reset_in_drain();
      test_rdlat2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
